// File: rtl/rtc_timer_bank_if.sv
// Configuration/status bundle between the APB register file and the timer bank.
// The register file drives config, strobes and mask; the bank returns status.
interface rtc_timer_bank_if #(
    parameter int N_CH    = 4,
    parameter int VAL_W   = 17,
    parameter int PRESC_W = 16
);
    logic                      tick_i;
    logic [N_CH-1:0]           cfg_upd_i;
    logic [N_CH-1:0]           cfg_en_i;
    logic [2*N_CH-1:0]         cfg_mode_i;
    logic [VAL_W*N_CH-1:0]     cfg_target_i;
    logic [PRESC_W*N_CH-1:0]   cfg_div_i;
    logic [N_CH-1:0]           irq_mask_i;
    logic [N_CH-1:0]           flag_clr_i;
    logic [VAL_W*N_CH-1:0]     value_o;
    logic [N_CH-1:0]           flag_o;
    logic [N_CH-1:0]           busy_o;
    logic                      irq_o;

    modport master (
        output tick_i, cfg_upd_i, cfg_en_i, cfg_mode_i,
        output cfg_target_i, cfg_div_i, irq_mask_i, flag_clr_i,
        input  value_o, flag_o, busy_o, irq_o
    );

    modport slave (
        input  tick_i, cfg_upd_i, cfg_en_i, cfg_mode_i,
        input  cfg_target_i, cfg_div_i, irq_mask_i, flag_clr_i,
        output value_o, flag_o, busy_o, irq_o
    );
endinterface

// File: rtl/rtc_timer_bank.sv
// Multi-channel RTC timer bank: per-channel prescaler, counter and
// IDLE/RUN/DONE FSM with sticky match flags and one combined interrupt.
module rtc_timer_bank #(
    parameter int N_CH    = 4,
    parameter int VAL_W   = 17,
    parameter int PRESC_W = 16
) (
    input  logic               pclk,
    input  logic               prst_n,
    rtc_timer_bank_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [N_CH-1:0][VAL_W-1:0] val_arr;
    logic [N_CH-1:0]            flag_arr;
    logic [N_CH-1:0]            busy_arr;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t               st_q;
        logic [1:0]           mode_q;
        logic [PRESC_W-1:0]   div_q;
        logic [PRESC_W-1:0]   presc_q;
        logic [VAL_W-1:0]     tgt_q;
        logic [VAL_W-1:0]     val_q;
        logic                 flag_q;
        logic                 busy_q;

        logic                 upd;
        logic [1:0]           mode_in;
        logic [VAL_W-1:0]     tgt_in;
        logic [PRESC_W-1:0]   div_in;
        logic [VAL_W-1:0]     val_inc;
        logic                 run_tick;
        logic                 step;
        logic                 match;

        assign upd     = bus.cfg_upd_i[c];
        assign mode_in = bus.cfg_mode_i[2*c +: 2];
        assign tgt_in  = bus.cfg_target_i[VAL_W*c +: VAL_W];
        assign div_in  = bus.cfg_div_i[PRESC_W*c +: PRESC_W];
        assign val_inc = val_q + VAL_W'(1);

        // A strobe in the same cycle swallows the tick for this channel.
        assign run_tick = !upd && bus.tick_i && (st_q == RUN);
        assign step     = run_tick && (presc_q == div_q);
        assign match    = step && (val_inc == tgt_q);

        // Channel FSM, prescaler, counter and latched configuration.
        always_ff @(posedge pclk or negedge prst_n) begin
            if (!prst_n) begin
                st_q    <= IDLE;
                mode_q  <= 2'b00;
                div_q   <= '0;
                presc_q <= '0;
                tgt_q   <= '0;
                val_q   <= '0;
                busy_q  <= 1'b0;
            end else if (upd) begin
                mode_q  <= mode_in;
                div_q   <= div_in;
                tgt_q   <= (tgt_in == '0) ? VAL_W'(1) : tgt_in;
                presc_q <= '0;
                val_q   <= '0;
                st_q    <= bus.cfg_en_i[c] ? RUN : IDLE;
                busy_q  <= bus.cfg_en_i[c];
            end else if (run_tick) begin
                if (!step) begin
                    presc_q <= presc_q + PRESC_W'(1);
                end else begin
                    presc_q <= '0;
                    if (!match) begin
                        val_q <= val_inc;
                    end else begin
                        unique case (1'b1)
                            (mode_q == 2'b01): begin
                                val_q <= '0;
                            end
                            (mode_q == 2'b10): begin
                                val_q <= val_inc;
                            end
                            default: begin
                                val_q  <= tgt_q;
                                st_q   <= DONE;
                                busy_q <= 1'b0;
                            end
                        endcase
                    end
                end
            end
        end

        // Sticky match flag; a new match beats a coincident clear.
        always_ff @(posedge pclk or negedge prst_n) begin
            if (!prst_n) begin
                flag_q <= 1'b0;
            end else if (match) begin
                flag_q <= 1'b1;
            end else if (bus.flag_clr_i[c]) begin
                flag_q <= 1'b0;
            end
        end

        assign val_arr[c]  = val_q;
        assign flag_arr[c] = flag_q;
        assign busy_arr[c] = busy_q;
    end

    assign bus.value_o = val_arr;
    assign bus.flag_o  = flag_arr;
    assign bus.busy_o  = busy_arr;
    assign bus.irq_o   = |(flag_arr & bus.irq_mask_i);

endmodule

// File: tb/tb_rtc_timer_bank.sv
// Directed bench for rtc_timer_bank: vector table per cycle plus
// hand-written sequences for wrap, same-cycle mask and async reset.
module tb_rtc_timer_bank;

    localparam int NC = 4;
    localparam int VW = 10;
    localparam int PW = 16;

    logic pclk;
    logic prst_n;

    rtc_timer_bank_if #(.N_CH(NC), .VAL_W(VW), .PRESC_W(PW)) bus ();

    rtc_timer_bank #(.N_CH(NC), .VAL_W(VW), .PRESC_W(PW)) u_dut (
        .pclk   (pclk),
        .prst_n (prst_n),
        .bus    (bus.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        string      name;
        int         ch;
        bit         upd;
        bit         en;
        logic [1:0] mode;
        int         tgt;
        int         dv;
        bit         tick;
        bit         clr;
        logic [3:0] mask;
        int         ev;
        bit         ef;
        bit         eb;
        bit         ei;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic void add(string nm, int ch, bit upd, bit en,
                                logic [1:0] mode, int tgt, int dv,
                                bit tick, bit clr, logic [3:0] mask,
                                int ev, bit ef, bit eb, bit ei);
        vec_t v;
        v.name = nm; v.ch = ch; v.upd = upd; v.en = en;
        v.mode = mode; v.tgt = tgt; v.dv = dv; v.tick = tick;
        v.clr = clr; v.mask = mask; v.ev = ev; v.ef = ef;
        v.eb = eb; v.ei = ei;
        tbl.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_cfg(int ch, bit en, logic [1:0] mode,
                           int tgt, int dv);
        logic [VW-1:0] t;
        logic [PW-1:0] d;
        t = tgt[VW-1:0];
        d = dv[PW-1:0];
        bus.cfg_en_i[ch]                = en;
        bus.cfg_mode_i[2*ch +: 2]       = mode;
        bus.cfg_target_i[VW*ch +: VW]   = t;
        bus.cfg_div_i[PW*ch +: PW]      = d;
    endtask

    // One clock: pulses driven at negedge, sampled 1 time unit past posedge.
    task automatic cyc(bit tk, logic [3:0] upd, logic [3:0] clr);
        @(negedge pclk);
        bus.tick_i     = tk;
        bus.cfg_upd_i  = upd;
        bus.flag_clr_i = clr;
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [31:0] stat(int ch);
        logic [VW-1:0] v;
        v = bus.value_o[VW*ch +: VW];
        return {19'd0, v, bus.flag_o[ch], bus.busy_o[ch], bus.irq_o};
    endfunction

    function automatic logic [31:0] want(int ev, bit ef, bit eb, bit ei);
        logic [VW-1:0] v;
        v = ev[VW-1:0];
        return {19'd0, v, ef, eb, ei};
    endfunction

    initial begin
        logic [3:0] oh;

        prst_n           = 1'b0;
        bus.tick_i       = 1'b0;
        bus.cfg_upd_i    = '0;
        bus.cfg_en_i     = '0;
        bus.cfg_mode_i   = '0;
        bus.cfg_target_i = '0;
        bus.cfg_div_i    = '0;
        bus.irq_mask_i   = '0;
        bus.flag_clr_i   = '0;

        // one-shot, div 0, target 3
        add("os_upd",   0,1,1,2'b00,3,0, 0,0,4'h0, 0,0,1,0);
        add("os_t1",    0,0,0,2'b00,0,0, 1,0,4'h0, 1,0,1,0);
        add("os_t2",    0,0,0,2'b00,0,0, 1,0,4'h0, 2,0,1,0);
        add("os_t3",    0,0,0,2'b00,0,0, 1,0,4'h0, 3,1,0,0);
        add("os_hold",  0,0,0,2'b00,0,0, 1,0,4'h0, 3,1,0,0);
        // flag set/clear priority and masking
        add("fl_upd",   0,1,1,2'b00,2,0, 0,0,4'h0, 0,1,1,0);
        add("fl_t1",    0,0,0,2'b00,0,0, 1,0,4'h0, 1,1,1,0);
        add("fl_setclr",0,0,0,2'b00,0,0, 1,1,4'h0, 2,1,0,0);
        add("fl_clr",   0,0,0,2'b00,0,0, 0,1,4'h0, 2,0,0,0);
        add("fl_upd1",  0,1,1,2'b11,1,0, 0,0,4'h0, 0,0,1,0);
        add("fl_m0",    0,0,0,2'b00,0,0, 1,0,4'h0, 1,1,0,0);
        add("fl_m1",    0,0,0,2'b00,0,0, 0,0,4'h1, 1,1,0,1);
        add("fl_m1clr", 0,0,0,2'b00,0,0, 0,1,4'h1, 1,0,0,0);
        // periodic, div 2, target 2
        add("per_upd",  1,1,1,2'b01,2,2, 0,0,4'h0, 0,0,1,0);
        add("per_t1",   1,0,0,2'b00,0,0, 1,0,4'h0, 0,0,1,0);
        add("per_t2",   1,0,0,2'b00,0,0, 1,0,4'h0, 0,0,1,0);
        add("per_t3",   1,0,0,2'b00,0,0, 1,0,4'h0, 1,0,1,0);
        add("per_t4",   1,0,0,2'b00,0,0, 1,0,4'h0, 1,0,1,0);
        add("per_t5",   1,0,0,2'b00,0,0, 1,0,4'h0, 1,0,1,0);
        add("per_t6",   1,0,0,2'b00,0,0, 1,0,4'h0, 0,1,1,0);
        add("per_clr",  1,0,0,2'b00,0,0, 0,1,4'h0, 0,0,1,0);
        add("per_t7",   1,0,0,2'b00,0,0, 1,0,4'h0, 0,0,1,0);
        add("per_t8",   1,0,0,2'b00,0,0, 1,0,4'h0, 0,0,1,0);
        add("per_t9",   1,0,0,2'b00,0,0, 1,0,4'h0, 1,0,1,0);
        add("per_t10",  1,0,0,2'b00,0,0, 1,0,4'h0, 1,0,1,0);
        add("per_t11",  1,0,0,2'b00,0,0, 1,0,4'h0, 1,0,1,0);
        add("per_t12",  1,0,0,2'b00,0,0, 1,0,4'h0, 0,1,1,0);
        // upd vs tick, target 0, disable
        add("c3_upd",   3,1,1,2'b10,100,0, 0,0,4'h0, 0,0,1,0);
        for (int i = 1; i <= 7; i++)
            add("c3_run", 3,0,0,2'b00,0,0, 1,0,4'h0, i,0,1,0);
        add("c3_updtk", 3,1,1,2'b10,0,0, 1,0,4'h0, 0,0,1,0);
        add("c3_tgt0",  3,0,0,2'b00,0,0, 1,0,4'h0, 1,1,1,0);
        add("c3_free",  3,0,0,2'b00,0,0, 1,0,4'h0, 2,1,1,0);
        add("c3_dis",   3,1,0,2'b00,5,0, 0,0,4'h0, 0,1,0,0);
        add("c3_idle",  3,0,0,2'b00,0,0, 1,0,4'h0, 0,1,0,0);
        add("c3_clr",   3,0,0,2'b00,0,0, 0,1,4'h0, 0,0,0,0);

        #12;
        chk("reset_val", {19'd0, bus.value_o[VW-1:0], 3'b000},
            32'd0);
        chk("reset_all", {bus.flag_o, bus.busy_o, 23'd0, bus.irq_o},
            32'd0);
        @(negedge pclk);
        prst_n = 1'b1;

        foreach (tbl[k]) begin
            oh = 4'b0001 << tbl[k].ch;
            if (tbl[k].upd)
                set_cfg(tbl[k].ch, tbl[k].en, tbl[k].mode,
                        tbl[k].tgt, tbl[k].dv);
            bus.irq_mask_i = tbl[k].mask;
            cyc(tbl[k].tick, tbl[k].upd ? oh : 4'h0,
                tbl[k].clr ? oh : 4'h0);
            chk(tbl[k].name, stat(tbl[k].ch),
                want(tbl[k].ev, tbl[k].ef, tbl[k].eb, tbl[k].ei));
        end

        // ch1 flag is still set: mask change shows up without a clock
        cyc(0, 4'h0, 4'h0);
        bus.irq_mask_i = 4'b0010;
        #1;
        chk("mask_on", {31'd0, bus.irq_o}, 32'd1);
        bus.irq_mask_i = 4'b0000;
        #1;
        chk("mask_off", {31'd0, bus.irq_o}, 32'd0);

        // ch2 free-run, target 5, run through the counter wrap
        set_cfg(2, 1, 2'b10, 5, 0);
        cyc(0, 4'b0100, 4'h0);
        for (int i = 0; i < 4; i++) cyc(1, 4'h0, 4'h0);
        chk("fr_4", stat(2), want(4, 0, 1, 0));
        cyc(1, 4'h0, 4'h0);
        chk("fr_5", stat(2), want(5, 1, 1, 0));
        cyc(0, 4'h0, 4'b0100);
        chk("fr_clr", stat(2), want(5, 0, 1, 0));
        for (int i = 0; i < 1018; i++) cyc(1, 4'h0, 4'h0);
        chk("fr_max", stat(2), want(1023, 0, 1, 0));
        cyc(1, 4'h0, 4'h0);
        chk("fr_wrap", stat(2), want(0, 0, 1, 0));

        // ch1 free-run to 4, then async reset mid-cycle
        set_cfg(1, 1, 2'b10, 100, 0);
        cyc(0, 4'b0010, 4'h0);
        for (int i = 0; i < 4; i++) cyc(1, 4'h0, 4'h0);
        bus.irq_mask_i = 4'hF;
        #1;
        chk("pre_rst", stat(1), want(4, 1, 1, 1));
        #1;
        prst_n = 1'b0;
        #1;
        chk("rst_val", {22'd0, bus.value_o[VW*1 +: VW]}, 32'd0);
        chk("rst_all", {19'd0, bus.flag_o, bus.busy_o, 4'd0,
            bus.irq_o}, 32'd0);
        @(negedge pclk);
        prst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, 4'h0, 4'h0);
        chk("post_rst", stat(1), want(0, 0, 0, 0));
        bus.irq_mask_i = 4'h0;
        cyc(0, 4'b0010, 4'h0);
        chk("re_upd", stat(1), want(0, 0, 1, 0));
        cyc(1, 4'h0, 4'h0);
        chk("re_tick", stat(1), want(1, 0, 1, 0));
        cyc(0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
